mem_arbiter: RTL

//  Shares the single virtual-address port of mem_ctrl between the CPU instruction-fetch port (I, read-only)
//  and load/store port (D, read/write). Sequences each access over synchronous RAM/IO with a fixed read latency.

---
 rtl/mem_arb_pkg.sv | 27 ++
 rtl/mem_arbiter.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and the arbitration rule for mem_arbiter.
package mem_arb_pkg;

  localparam int STREAK_W = 4;
  localparam int LAT_W    = 3;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_e;

  // D wins by default; I wins when it is alone or when D has used up its streak.
  function automatic grant_e pick_winner(input logic                i_req,
                                         input logic                d_req,
                                         input logic [STREAK_W-1:0] streak,
                                         input logic [STREAK_W-1:0] max_streak);
    if (d_req && !(i_req && (streak == max_streak))) return GRANT_D;
    return GRANT_I;
  endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of mem_ctrl's single virtual port.
// One access in flight at a time: IDLE -> ACCESS -> RESP -> IDLE.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int MAX_D_STREAK = 4
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              iReq,
  input  logic [ADDR_W-1:0] iAddr,
  output logic              iAck,
  output logic [DATA_W-1:0] iData,
  input  logic              dReq,
  input  logic              dWe,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWdata,
  output logic              dAck,
  output logic [DATA_W-1:0] dRdata,
  output logic              dErr,
  output logic [ADDR_W-1:0] addressVirt,
  output logic [DATA_W-1:0] dataInVirt,
  output logic              wEnVirt,
  input  logic [DATA_W-1:0] dataOutVirt,
  output logic              busy
);

  localparam logic [STREAK_W-1:0] MAX_STREAK = STREAK_W'(MAX_D_STREAK);
  localparam logic [LAT_W-1:0]    LAT_LAST   = LAT_W'(READ_LATENCY);

  state_e              state_q;
  grant_e              grant_q;
  logic                we_q;
  logic                mis_q;
  logic [LAT_W-1:0]    lat_cnt_q;
  logic [STREAK_W-1:0] streak_q;
  logic [ADDR_W-1:0]   addr_virt_q;
  logic [DATA_W-1:0]   data_in_q;
  logic                wen_q;
  logic [DATA_W-1:0]   i_data_q;
  logic [DATA_W-1:0]   d_rdata_q;
  logic                i_ack_q;
  logic                d_ack_q;
  logic                d_err_q;

  grant_e              winner_d;
  logic [STREAK_W-1:0] streak_d;
  logic                d_misaligned;

  assign d_misaligned = (dAddr[1:0] != 2'b00);

  // Winner and the streak value that goes with it, used only on an IDLE sample edge.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    winner_d = pick_winner(iReq, dReq, streak_q, MAX_STREAK);
    streak_d = '0;
    if (winner_d == GRANT_D && iReq) begin
      streak_d = (streak_q == MAX_STREAK) ? streak_q : streak_q + 1'b1;
    end
  end

  // Access sequencer with registered outputs toward mem_ctrl and the requesters.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      // Data holding registers are cleared too so every output reads 0 in reset.
      state_q     <= ST_IDLE;
      grant_q     <= GRANT_D;
      we_q        <= 1'b0;
      mis_q       <= 1'b0;
      lat_cnt_q   <= '0;
      streak_q    <= '0;
      addr_virt_q <= '0;
      data_in_q   <= '0;
      wen_q       <= 1'b0;
      i_data_q    <= '0;
      d_rdata_q   <= '0;
      i_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      d_err_q     <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values; the
      // defaults below make acks and the write strobe single-cycle pulses.
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      wen_q     <= 1'b0;
      data_in_q <= '0;
      case (state_q)
        ST_IDLE: begin
          if (iReq || dReq) begin
            grant_q   <= winner_d;
            streak_q  <= streak_d;
            lat_cnt_q <= '0;
            state_q   <= ST_ACCESS;
            if (winner_d == GRANT_D) begin
              we_q        <= dWe;
              mis_q       <= d_misaligned;
              addr_virt_q <= dAddr;
              if (dWe && !d_misaligned) begin
                wen_q     <= 1'b1;
                data_in_q <= dWdata;
              end
            end else begin
              we_q        <= 1'b0;
              mis_q       <= 1'b0;
              addr_virt_q <= iAddr & ~ADDR_W'(3);
            end
          end
        end
        ST_ACCESS: begin
          if (we_q || mis_q) begin
            state_q <= ST_RESP;
            d_ack_q <= 1'b1;
            d_err_q <= mis_q;
          end else if (lat_cnt_q == LAT_LAST) begin
            state_q <= ST_RESP;
            if (grant_q == GRANT_I) begin
              i_data_q <= dataOutVirt;
              i_ack_q  <= 1'b1;
            end else begin
              d_rdata_q <= dataOutVirt;
              d_ack_q   <= 1'b1;
            end
          end else begin
            lat_cnt_q <= lat_cnt_q + 1'b1;
          end
        end
        ST_RESP: begin
          state_q     <= ST_IDLE;
          addr_virt_q <= '0;
        end
        default: begin
          state_q     <= ST_IDLE;
          addr_virt_q <= '0;
        end
      endcase
    end
  end

  assign iAck        = i_ack_q;
  assign iData       = i_data_q;
  assign dAck        = d_ack_q;
  assign dRdata      = d_rdata_q;
  assign dErr        = d_err_q;
  assign addressVirt = addr_virt_q;
  assign dataInVirt  = data_in_q;
  assign wEnVirt     = wen_q;
  assign busy        = (state_q != ST_IDLE);

endmodule
